// File: rtl/stopwatch_display_scan_if.sv
// stopwatch_display_scan_if: digit/control inputs and display pin outputs of the scanner
interface stopwatch_display_scan_if;
  logic        enable;
  logic [15:0] digits;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [3:0]  dp_pos;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;
  modport master(output enable, digits, blank_lz, blink_mask, dp_pos, input an, seg, dp, frame_tick);
  modport slave(input enable, digits, blank_lz, blink_mask, dp_pos, output an, seg, dp, frame_tick);
endinterface

// File: rtl/stopwatch_display_scan.sv
// stopwatch_display_scan: 4-digit common-anode seven-segment scanner with frame snapshot, blanking and blink
module stopwatch_display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input logic clk,
  input logic reset,
  stopwatch_display_scan_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;
  logic [15:0]   r_snap;
  logic [FW-1:0] r_fcnt;
  logic          r_bph;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_tick;
  logic          w_term;
  logic          w_frame;
  logic          w_fwrap;
  logic          w_lz4;
  logic          w_lz3;
  logic          w_blank;
  logic [3:0]    w_dig;
  logic [6:0]    w_seg;
  assign w_term  = r_pre == PW'(SCAN_DIV - 1);
  assign w_frame = bus.enable & w_term & (r_idx == 2'd3);
  assign w_fwrap = r_fcnt == FW'(BLINK_FRAMES - 1);
  assign w_dig   = r_snap[{r_idx, 2'b00} +: 4];
  assign w_lz4   = bus.blank_lz & (r_snap[15:12] == 4'd0);
  assign w_lz3   = w_lz4 & (r_snap[11:8] == 4'd0);
  assign w_blank = (r_idx == 2'd3 & w_lz4) | (r_idx == 2'd2 & w_lz3) | (bus.blink_mask[r_idx] & r_bph);
  // Active-low gfedcba pattern of the digit currently being scanned; non-BCD shows a dash
  always_comb begin
    w_seg = 7'b0111111;
    case (w_dig)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
      default: w_seg = 7'b0111111;
    endcase
  end
  // Scan position, frame-coherent snapshot and blink phase; everything freezes while disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre  <= '0;
      r_idx  <= 2'd0;
      r_snap <= 16'd0;
      r_fcnt <= '0;
      r_bph  <= 1'b0;
    end else if (bus.enable) begin
      r_pre <= w_term ? '0 : r_pre + 1'b1;
      if (w_term) r_idx <= r_idx + 1'b1;
      if (w_frame) begin
        r_snap <= bus.digits;
        r_fcnt <= w_fwrap ? '0 : r_fcnt + 1'b1;
        if (w_fwrap) r_bph <= ~r_bph;
      end
    end
  end
  // Registered pin drive; the first cycle of each slot is dark to suppress ghosting
  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= r_pre == '0 ? 4'b1111 : ~(4'b0001 << r_idx);
      r_seg <= w_blank ? 7'b1111111 : w_seg;
      r_dp  <= w_blank | ~bus.dp_pos[r_idx];
    end
    r_tick <= !reset && w_frame;
  end
  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_tick = r_tick;
endmodule
